board_ram_arbiter: RTL
======================

# board_ram_arbiter

Shares the single read/write port of the 16-entry tile board RAM among several requesters on the CLOCK_50 domain: the board initializer/shuffler, the in-game FSM and an auxiliary reader such as the match checker or score logic. It sits between those requesters and the board RAM's game-side port. It grants one transaction at a time through a small FSM. An owner may hold a lock for atomic read-compare-write sequences, such as flipping or clearing two tiles.

## Interface
Parameters:
- N_REQ, 3, number of requesters; index 0 = initializer, 1 = game FSM, 2 = auxiliary
- AW, 4, RAM address width (16 tiles)
- DW, 8, tile word width

Ports:
- CLOCK_50  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high
- req  in  N_REQ  per-requester access request
- lock  in  N_REQ  per-requester lock hint; honoured only for the current owner
- req_addr  in  N_REQ*AW  packed addresses; slice i belongs to requester i
- req_we  in  N_REQ  per-requester write enable
- req_wdata  in  N_REQ*DW  packed write data
- gnt  out  N_REQ  one-hot, one-cycle grant pulse
- rvalid  out  N_REQ  one-hot, one-cycle completion pulse
- rdata  out  DW  read data; valid only while any rvalid bit is set
- ram_addr  out  AW  RAM address, registered
- ram_we  out  1  RAM write enable, registered
- ram_wdata  out  DW  RAM write data, registered
- ram_rdata  in  DW  RAM read data; synchronous read, 1-cycle latency
- busy  out  1  high in any state other than IDLE
- owner  out  $clog2(N_REQ)  index of the last or current winner

## Operation
- FSM states:
  - IDLE: sample req. If any bit is set, register the winner, drive ram_addr/ram_we/ram_wdata from the winner's slice, and go to ISSUE.
  - ISSUE: gnt[owner]=1. ram_we is high this cycle only if the winner's req_we was set. Next state is RESP.
  - RESP: rvalid[owner]=1 and rdata=ram_rdata. For writes, rvalid is a completion ack and rdata is don't-care.
    - If lock[owner] and req[owner] are both high this cycle, reload ram_* from the owner's slice and go to ISSUE; no arbitration occurs.
    - Otherwise go to IDLE.
- Requester rules:
  - Hold req, addr, we and wdata stable from assertion until gnt.
  - A new transaction may be presented from the cycle after gnt.
  - req, addr, we and wdata are sampled only in IDLE, and in RESP for a locked continuation.
  - Changes in other cycles are ignored.
- lock from a non-owner is ignored. lock with req low in RESP releases the bus, and the FSM goes to IDLE.
- ram_we is 0 in IDLE and RESP. ram_addr and ram_wdata hold their last values.
- Reset behaviour:
  - Any cycle with reset high: next state is IDLE.
  - gnt, rvalid, ram_we and busy are 0.
  - ram_addr, ram_wdata and owner are 0.
  - The round-robin pointer is N_REQ-1.
  - An in-flight transaction is dropped: no gnt or rvalid is ever issued for it.

## Timing
- Request seen in IDLE at cycle T: gnt at T+1, RAM access at T+1, rvalid and rdata at T+2.
- Unlocked throughput: one access per 3 cycles (IDLE, ISSUE, RESP).
- Locked burst: one access per 2 cycles (ISSUE/RESP alternate).
- gnt and rvalid are never high in the same cycle. At most one bit of each is set.
- rdata is a combinational pass-through of ram_rdata. All other outputs are registered.

## Configuration
- BOARD_ARB_RR_EN defined: round-robin arbitration. Search starts at (last owner + 1) mod N_REQ. The pointer updates on each IDLE→ISSUE, not on locked continuations.
- Not defined: fixed priority, where the lowest index wins. The pointer logic is absent, and owner still reports the winner.

## Structure
- Shared package board_arb_pkg holds:
  - state enum {IDLE, ISSUE, RESP}
  - N_REQ, AW and DW defaults
  - requester index constants REQ_INIT=0, REQ_GAME=1, REQ_AUX=2
- Sub-module board_arb_pick is a combinational picker. Inputs: req vector and pointer. Outputs: winner index and found flag. The RR/fixed choice is selected by the macro inside the picker.

## Test plan
- Single read: reset, RAM[5]=8'h2A, req[1] with addr 5 and we=0 at T → gnt[1] at T+1 with ram_addr=5 and ram_we=0; rvalid[1] at T+2 with rdata=8'h2A.
- Write then read: req[0] writes 8'h11 to addr 3 → ram_we=1 only at the gnt cycle. A following read of addr 3 by req[2] returns 8'h11.
- Contention: req=3'b111 held. With RR, grant order is 0,1,2,0. Without RR, requester 0 is granted repeatedly. Each grant is 3 cycles apart.
- Lock: req[1] and lock[1] issue 2 reads (addr 4, 9) while req[0] is pending → grants to 1 at cycles T+1 and T+3; requester 0 is granted only after lock drops.
- Lock by non-owner: lock[2]=1 while requester 0 owns → no continuation for 2; the FSM returns to IDLE.
- Reset mid-op: reset asserted in ISSUE → next cycle IDLE with gnt, rvalid, ram_we and busy at 0; no rvalid ever appears for that transaction.

Source files
------------

// File: rtl/board_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : board_arb_pkg
//  Description : Shared types and constants for the tile board RAM arbiter:
//                FSM state encoding, default geometry and requester indices.
//  Revision    : 1.0  initial release
// ============================================================================
package board_arb_pkg;

  // Arbiter FSM states; two bits cover the three states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  // Default geometry: three requesters, 16 tiles, 8-bit tile words.
  localparam int N_REQ_DEFAULT = 3;
  localparam int AW_DEFAULT    = 4;
  localparam int DW_DEFAULT    = 8;

  // Requester slot assignment.
  localparam int REQ_INIT = 0;
  localparam int REQ_GAME = 1;
  localparam int REQ_AUX  = 2;

endpackage
`default_nettype wire

// File: rtl/board_arb_pick.sv
`default_nettype none
// ============================================================================
//  Module      : board_arb_pick
//  Description : Combinational winner picker for the board RAM arbiter.
//                With BOARD_ARB_RR_EN defined the search starts one past
//                the pointer (round robin); otherwise the lowest requesting
//                index wins and the pointer is ignored.
//  Revision    : 1.0  initial release
// ============================================================================
module board_arb_pick
  import board_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [IW-1:0]    winner,
  output logic             found
);

`ifdef BOARD_ARB_RR_EN
  // Round robin: first requester found scanning upward from ptr+1, wrapping.
  always_comb begin : p_pick_rr
    int idx;
    idx    = 0;
    winner = '0;
    found  = 1'b0;
    for (int off = 1; off <= N_REQ; off++) begin
      idx = (int'(ptr) + off) % N_REQ;
      if (!found && req[IW'(idx)]) begin
        found  = 1'b1;
        winner = IW'(idx);
      end
    end
  end
`else
  // The pointer has no meaning under fixed priority.
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Fixed priority: scanning downward lets the lowest index overwrite last.
  always_comb begin : p_pick_fixed
    winner = '0;
    found  = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[IW'(i)]) begin
        found  = 1'b1;
        winner = IW'(i);
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/board_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : board_ram_arbiter
//  Description : Shares the single game-side port of the 16-tile board RAM
//                among the initializer, game FSM and auxiliary reader. One
//                transaction at a time: IDLE -> ISSUE (grant, RAM access)
//                -> RESP (completion, read data). The owner may chain
//                accesses with lock+req for atomic read-modify-write.
//                Define BOARD_ARB_RR_EN for round-robin arbitration;
//                default is fixed priority (lowest index wins).
//  Revision    : 1.0  initial release
// ============================================================================
module board_ram_arbiter
  import board_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT,
  parameter int AW    = AW_DEFAULT,
  parameter int DW    = DW_DEFAULT
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         lock,
  input  logic [N_REQ*AW-1:0]      req_addr,
  input  logic [N_REQ-1:0]         req_we,
  input  logic [N_REQ*DW-1:0]      req_wdata,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         rvalid,
  output logic [DW-1:0]            rdata,
  output logic [AW-1:0]            ram_addr,
  output logic                     ram_we,
  output logic [DW-1:0]            ram_wdata,
  input  logic [DW-1:0]            ram_rdata,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] owner
);

  localparam int IW = $clog2(N_REQ);

  arb_state_e        state_q, state_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  rvalid_q, rvalid_d;
  logic [AW-1:0]     ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [DW-1:0]     ram_wdata_q, ram_wdata_d;
  logic              busy_q, busy_d;

  logic [IW-1:0]     pick_ptr;
  logic [IW-1:0]     winner;
  logic              found;

  // Slice selected for loading the RAM command: the fresh winner in IDLE,
  // the current owner for a locked continuation in RESP.
  logic [IW-1:0]     sel;
  logic [AW-1:0]     sel_addr;
  logic              sel_we;
  logic [DW-1:0]     sel_wdata;

`ifdef BOARD_ARB_RR_EN
  logic [IW-1:0]     ptr_q, ptr_d;

  // Pointer follows each fresh IDLE->ISSUE win; locked continuations leave it.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE && found) begin
      ptr_d = winner;
    end
  end

  // Round-robin pointer register; resets so that requester 0 is searched first.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      ptr_q <= IW'(N_REQ - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign pick_ptr = ptr_q;
`else
  assign pick_ptr = '0;
`endif

  board_arb_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req    (req),
    .ptr    (pick_ptr),
    .winner (winner),
    .found  (found)
  );

  // Extract the command fields of the selected requester.
  always_comb begin
    sel       = (state_q == IDLE) ? winner : owner_q;
    sel_addr  = req_addr[int'(sel)*AW +: AW];
    sel_we    = req_we[sel];
    sel_wdata = req_wdata[int'(sel)*DW +: DW];
  end

  // Next-state and next-output logic; every output is the registered copy.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    gnt_d       = '0;
    rvalid_d    = '0;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d        = ISSUE;
          owner_d        = winner;
          gnt_d[winner]  = 1'b1;
          ram_addr_d     = sel_addr;
          ram_we_d       = sel_we;
          ram_wdata_d    = sel_wdata;
        end
      end
      ISSUE: begin
        state_d           = RESP;
        rvalid_d[owner_q] = 1'b1;
      end
      RESP: begin
        if (lock[owner_q] && req[owner_q]) begin
          state_d        = ISSUE;
          gnt_d[owner_q] = 1'b1;
          ram_addr_d     = sel_addr;
          ram_we_d       = sel_we;
          ram_wdata_d    = sel_wdata;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset drops any in-flight transaction.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      gnt_q       <= '0;
      rvalid_q    <= '0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign gnt       = gnt_q;
  assign rvalid    = rvalid_q;
  assign rdata     = ram_rdata;
  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;
  assign busy      = busy_q;
  assign owner     = owner_q;

endmodule
`default_nettype wire
